// File: rtl/fiat_25519_carry_mul_mac_pipe.sv
// fiat_25519_carry_mul_mac_pipe
//
// Pipelined signed multiply-accumulate unit for the fiat_25519 carry_mul limb
// datapath. Each accepted beat multiplies two signed operands. The product is
// resized (sign-extended or LSB-truncated) to dout_WIDTH and then added into a
// wrap-around accumulator. A beat tagged acc_first starts a fresh sum. A beat
// tagged acc_last emits the sum on dout and clears the accumulator. With
// first=last on every beat the block is a plain pipelined multiplier.
//
// Ports:
//   ap_clk     - clock; all state updates on the rising edge
//   ap_rst_n   - synchronous active-low reset
//   in_valid   - input beat valid
//   in_ready   - block accepts a beat this cycle (= !out_valid || out_ready)
//   din0, din1 - signed operands
//   acc_first  - beat starts a new accumulation
//   acc_last   - beat ends the accumulation; the sum is emitted
//   out_valid  - dout holds a result
//   out_ready  - downstream accepts the result
//   dout       - signed result
//
// Latency: a last beat accepted at edge N shows out_valid after edge
// N+NUM_STAGE+1. The accepted operands are captured first, and the product
// then travels through NUM_STAGE register levels into the accumulate stage.
module fiat_25519_carry_mul_mac_pipe #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64,
    parameter int NUM_STAGE  = 3
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    input  logic                         acc_first,
    input  logic                         acc_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [dout_WIDTH-1:0] dout
);

    localparam int PW = din0_WIDTH + din1_WIDTH;

    // One global advance enable: a held result freezes the whole pipeline.
    logic adv;

    // Operand capture register
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic                         v0_q, f0_q, l0_q;

    // Product pipeline
    logic signed [PW-1:0]         prod;
    logic [dout_WIDTH-1:0]        prod_ext;
    logic [dout_WIDTH-1:0]        p_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]         v_q, f_q, l_q;

    // Accumulate stage
    logic [dout_WIDTH-1:0]        acc_q, acc_d;
    logic [dout_WIDTH-1:0]        dout_q, dout_d;
    logic                         out_valid_q, out_valid_d;
    logic [dout_WIDTH-1:0]        base, sum;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Operand capture; only the valid bit needs a reset value.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            v0_q <= 1'b0;
        end else if (adv) begin
            v0_q <= in_valid;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (adv) begin
            a_q  <= din0;
            b_q  <= din1;
            f0_q <= acc_first;
            l0_q <= acc_last;
        end
    end

    // Full-width signed product, then resized to the accumulator width.
    assign prod = a_q * b_q;

    generate
        if (dout_WIDTH <= PW) begin : g_trunc
            assign prod_ext = prod[dout_WIDTH-1:0];
        end else begin : g_sext
            assign prod_ext = {{(dout_WIDTH - PW){prod[PW-1]}}, prod};
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            v_q <= '0;
        end else if (adv) begin
            v_q[0] <= v0_q;
            for (int i = 1; i < NUM_STAGE; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (adv) begin
            p_q[0] <= prod_ext;
            f_q[0] <= f0_q;
            l_q[0] <= l0_q;
            for (int i = 1; i < NUM_STAGE; i++) begin
                p_q[i] <= p_q[i-1];
                f_q[i] <= f_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    // Accumulate / emit
    always_comb begin
        base        = f_q[NUM_STAGE-1] ? '0 : acc_q;
        sum         = base + p_q[NUM_STAGE-1];
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            if (v_q[NUM_STAGE-1]) begin
                if (l_q[NUM_STAGE-1]) begin
                    dout_d      = sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d       = sum;
                    out_valid_d = 1'b0;
                end
            end else begin
                // adv with out_valid set implies out_ready, so the result is consumed.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_fiat_25519_carry_mul_mac_pipe.sv
// Bench for fiat_25519_carry_mul_mac_pipe. Four builds share one stimulus bus:
//   sel 0: defaults (NUM_STAGE=3, dout_WIDTH=64)
//   sel 1: dout_WIDTH=32
//   sel 2: NUM_STAGE=1
//   sel 3: NUM_STAGE=5
// Only the selected build sees in_valid; its outputs are muxed onto cur_*.
module tb_fiat_25519_carry_mul_mac_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic [31:0] din0, din1;
    logic        acc_first, acc_last;
    logic        out_ready;
    logic [1:0]  sel;

    logic [3:0]  iv, rdy, ov;
    logic [63:0] d_s3, d_s1, d_s5;
    logic [31:0] d_w32;

    logic        cur_in_ready, cur_out_valid;
    logic [63:0] cur_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        for (int k = 0; k < 4; k++) iv[k] = in_valid && (sel == 2'(k));
    end

    fiat_25519_carry_mul_mac_pipe u_s3 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(ov[0]), .out_ready(out_ready), .dout(d_s3)
    );

    fiat_25519_carry_mul_mac_pipe #(.dout_WIDTH(32)) u_w32 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(ov[1]), .out_ready(out_ready), .dout(d_w32)
    );

    fiat_25519_carry_mul_mac_pipe #(.NUM_STAGE(1)) u_s1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(ov[2]), .out_ready(out_ready), .dout(d_s1)
    );

    fiat_25519_carry_mul_mac_pipe #(.NUM_STAGE(5)) u_s5 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[3]), .in_ready(rdy[3]),
        .din0(din0), .din1(din1), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(ov[3]), .out_ready(out_ready), .dout(d_s5)
    );

    always_comb begin
        cur_in_ready  = rdy[sel];
        cur_out_valid = ov[sel];
        case (sel)
            2'd0:    cur_dout = d_s3;
            2'd1:    cur_dout = {32'h0, d_w32};
            2'd2:    cur_dout = d_s1;
            default: cur_dout = d_s5;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] s);
        case (s)
            2'd2:    return 2;
            2'd3:    return 6;
            default: return 4;
        endcase
    endfunction

    // Send one beat to an idle build, then watch 10 cycles for results.
    task automatic send_beat(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                             input logic f, input logic l, input logic [63:0] exp);
        int lat;
        int nres;
        logic [63:0] got;
        lat  = 0;
        nres = 0;
        got  = '0;
        @(negedge ap_clk);
        sel = s; in_valid = 1'b1; din0 = a; din1 = b; acc_first = f; acc_last = l;
        out_ready = 1'b1;
        #1;
        check("idle_in_ready", 64'(cur_in_ready), 64'd1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge ap_clk);
            #1;
            if (cur_out_valid) begin
                nres++;
                if (lat == 0) begin
                    lat = k;
                    got = cur_dout;
                end
            end
        end
        if (l) begin
            check("latency", 64'(lat), 64'(lat_of(s)));
            check("dout", got, exp);
            check("result_count", 64'(nres), 64'd1);
        end else begin
            check("no_result_midrun", 64'(nres), 64'd0);
        end
    endtask

    // Full-rate random tags against a reference accumulator.
    task automatic run_random(input logic [1:0] s, input int nbeats);
        logic [63:0] exp_q[$];
        longint acc_m;
        int a, b;
        logic f, l;
        acc_m = 0;
        for (int cyc = 0; cyc < nbeats + 12; cyc++) begin
            @(negedge ap_clk);
            sel = s;
            out_ready = 1'b1;
            #1;
            if (cur_out_valid) begin
                if (exp_q.size() == 0) check("rnd_extra_result", 64'd1, 64'd0);
                else check("rnd_dout", cur_dout, exp_q.pop_front());
            end
            if (cyc < nbeats) begin
                a = int'($urandom_range(2000)) - 1000;
                b = int'($urandom_range(2000)) - 1000;
                f = (cyc == 0) || ($urandom_range(3) == 0);
                l = (cyc == nbeats - 1) || ($urandom_range(2) == 0);
                in_valid = 1'b1; din0 = a; din1 = b; acc_first = f; acc_last = l;
                check("rnd_in_ready", 64'(cur_in_ready), 64'd1);
                acc_m = (f ? 64'sd0 : acc_m) + longint'(a) * longint'(b);
                if (l) begin
                    exp_q.push_back(64'(acc_m));
                    acc_m = 0;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        logic        l;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [63:0] bp_exp[8];
        logic [63:0] held;
        int sent, got, stall;
        logic seen;

        vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd12, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFAC};
        vecs[1]  = '{2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[2]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        // 3*4 + (-5*2) + 10*10 = 102
        vecs[3]  = '{2'd0, 32'd3, 32'd4, 1'b1, 1'b0, 64'd0};
        vecs[4]  = '{2'd0, 32'hFFFF_FFFB, 32'd2, 1'b0, 1'b0, 64'd0};
        vecs[5]  = '{2'd0, 32'd10, 32'd10, 1'b0, 1'b1, 64'd102};
        // new run restarts from 0: 2*3 + 1*1
        vecs[6]  = '{2'd0, 32'd2, 32'd3, 1'b1, 1'b0, 64'd0};
        vecs[7]  = '{2'd0, 32'd1, 32'd1, 1'b0, 1'b1, 64'd7};
        // last without first adds onto cleared acc
        vecs[8]  = '{2'd0, 32'd5, 32'd5, 1'b0, 1'b1, 64'd25};
        // first mid-run discards 81
        vecs[9]  = '{2'd0, 32'd9, 32'd9, 1'b1, 1'b0, 64'd0};
        vecs[10] = '{2'd0, 32'd2, 32'd2, 1'b1, 1'b0, 64'd0};
        vecs[11] = '{2'd0, 32'd1, 32'd3, 1'b0, 1'b1, 64'd7};
        // 32-bit build: 0xFFFFFFFE + 1 and truncation of 2^32
        vecs[12] = '{2'd1, 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0, 64'd0};
        vecs[13] = '{2'd1, 32'd1, 32'd1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF};
        vecs[14] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 64'd0};
        vecs[15] = '{2'd2, 32'hFFFF_FFF9, 32'd12, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFAC};
        vecs[16] = '{2'd3, 32'd100, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FED4};

        ap_rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
        acc_first = 1'b0; acc_last = 1'b0; out_ready = 1'b1; sel = 2'd0;

        repeat (3) @(posedge ap_clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check("reset_out_valid", 64'(cur_out_valid), 64'd0);
            check("reset_dout", cur_dout, 64'd0);
            check("reset_in_ready", 64'(cur_in_ready), 64'd1);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            send_beat(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].l, vecs[i].exp);
        end

        // Backpressure: 8 plain beats, first result held for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            bp_exp[i] = 64'(longint'(i + 1) * longint'(-(i * 1000 + 7)));
        end
        sent = 0; got = 0; stall = 0; seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge ap_clk);
            sel = 2'd0;
            if (cur_out_valid && !seen) begin
                seen = 1'b1;
                held = cur_dout;
            end
            out_ready = !(seen && stall < 5);
            in_valid  = (sent < 8);
            din0 = 32'(sent + 1);
            din1 = 32'(-(sent * 1000 + 7));
            acc_first = 1'b1; acc_last = 1'b1;
            #1;
            if (!out_ready) begin
                stall++;
                check("bp_in_ready", 64'(cur_in_ready), 64'd0);
                check("bp_out_valid", 64'(cur_out_valid), 64'd1);
                check("bp_dout_stable", cur_dout, held);
            end
            if (in_valid && cur_in_ready) sent++;
            if (cur_out_valid && out_ready) begin
                check("bp_order", cur_dout, bp_exp[got]);
                got++;
            end
        end
        @(negedge ap_clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 64'(got), 64'd8);
        check("bp_stall_cycles", 64'(stall), 64'd5);
        repeat (10) @(posedge ap_clk);

        // Reset mid-run drops the partial sum 3*4 + 5*5.
        @(negedge ap_clk);
        sel = 2'd0; in_valid = 1'b1; din0 = 32'd3; din1 = 32'd4;
        acc_first = 1'b1; acc_last = 1'b0;
        @(negedge ap_clk);
        din0 = 32'd5; din1 = 32'd5; acc_first = 1'b0;
        @(negedge ap_clk);
        in_valid = 1'b0; ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        check("rst_out_valid", 64'(cur_out_valid), 64'd0);
        check("rst_in_ready", 64'(cur_in_ready), 64'd1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge ap_clk);
            #1;
            if (cur_out_valid) got++;
        end
        check("rst_no_stale_result", 64'(got), 64'd0);
        send_beat(2'd0, 32'd6, 32'd7, 1'b0, 1'b1, 64'd42);

        run_random(2'd2, 40);
        run_random(2'd3, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
